monitor_sequencer: RTL
======================

MONITOR_SEQUENCER -- requirements
Module: monitor_sequencer

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of symbol-trace requesters.
REQ-002 SHALL have parameter NUM_REPORT, default 4, number of automaton report outputs.
REQ-003 SHALL have parameter IDX_W, default 16, width of the beat index counter.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester beat valid.
REQ-007 SHALL have port req_symbol  input  NUM_REQ x 8  per-requester symbol.
REQ-008 SHALL have port req_last  input  NUM_REQ  beat is the last of its trace.
REQ-009 SHALL have port req_ready  output  NUM_REQ  beat accepted when valid and ready are both high.
REQ-010 SHALL have port auto_reset  output  1  active-high reset to the automaton.
REQ-011 SHALL have port auto_run  output  1  automaton step enable.
REQ-012 SHALL have port auto_symbols  output  8  symbol to the automaton.
REQ-013 SHALL have port auto_report  input  NUM_REPORT  automaton report-state outputs.
REQ-014 SHALL have port viol_valid  output  1  one-cycle violation pulse.
REQ-015 SHALL have ports viol_src (clog2 NUM_REQ), viol_report (NUM_REPORT) and viol_index (IDX_W), all outputs, qualified by viol_valid.
REQ-016 SHALL have ports trace_done  output  1  (one-cycle pulse), trace_src  output  clog2 NUM_REQ, and trace_viol  output  1  (the trace reported at least once).
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, INIT, STREAM, DRAIN and DONE, plus ABORT when the configuration macro is defined.
REQ-019 IDLE: if any req_valid is high, SHALL grant round-robin starting at the requester after the last owner (requester 0 after reset), latch that requester as owner, and go to INIT.
REQ-020 INIT: SHALL hold for exactly one cycle with auto_reset=1, auto_run=0 and all req_ready=0, clear the beat index, then go to STREAM.
REQ-021 STREAM: SHALL drive auto_symbols = owner req_symbol, auto_run = owner req_valid and owner req_ready = 1; all other req_ready SHALL stay 0.
REQ-022 The first beat presented in STREAM is the automaton's start-of-data cycle; a stalled owner (valid low) SHALL hold auto_run=0 with no state change.
REQ-023 auto_report SHALL be sampled in the cycle after each accepted beat; a nonzero sample SHALL pulse viol_valid with viol_src=owner, viol_report=sample and viol_index=index of the beat that caused it.
REQ-024 The beat index SHALL increment per accepted beat and saturate at 2^IDX_W-1 (no wrap).
REQ-025 Accepting a beat with req_last=1 SHALL go to DRAIN; DRAIN SHALL last one cycle with auto_run=0 and sample the final report, then go to DONE.
REQ-026 DONE: SHALL pulse trace_done with trace_src=owner and trace_viol, advance the round-robin pointer, and return to IDLE; the next trace SHALL always pass through INIT.
REQ-027 A report sample and the acceptance of the next beat in the same cycle SHALL both take effect.
REQ-028 In IDLE, DRAIN and DONE, all req_ready SHALL be 0 and auto_run SHALL be 0.

Reset
REQ-029 While reset_n=0: state=IDLE, auto_reset=1, auto_run=0, auto_symbols=0, req_ready=0, viol_valid=0, trace_done=0, trace_viol=0, busy=0, index=0, round-robin pointer=requester 0.
REQ-030 reset_n low mid-trace SHALL abandon the trace with no trace_done; the owner's remaining beats SHALL be presented again as a new trace after reset.

Configuration
REQ-031 Macro MONITOR_SEQ_EARLY_ABORT_EN SHALL select the abort behaviour.
REQ-032 With MONITOR_SEQ_EARLY_ABORT_EN: the first violation in a trace SHALL enter ABORT, which holds owner req_ready=1 and auto_run=0, discards beats until the req_last beat is accepted, then goes to DONE; further violations in that trace SHALL be suppressed.
REQ-033 Without MONITOR_SEQ_EARLY_ABORT_EN: ABORT SHALL not exist, every violation SHALL pulse viol_valid, and streaming SHALL continue to req_last.

Verification
REQ-034 Reset pulse, then req0 sends 3 beats (last on the 3rd) with report 0 -> INIT one cycle with auto_reset=1, 3 auto_run cycles, trace_done=1 with trace_src=0 and trace_viol=0.
REQ-035 req0 and req1 both valid in IDLE, back-to-back traces -> order req0, req1, req0; a second INIT precedes each trace.
REQ-036 auto_report=4'b0010 after beat index 5 -> viol_valid=1 with viol_index=5 and viol_report=4'b0010, and later trace_viol=1.
REQ-037 With MONITOR_SEQ_EARLY_ABORT_EN, violation at beat 2 of a 10-beat trace -> single viol_valid, beats 3..9 accepted with auto_run=0, then trace_done.
REQ-038 reset_n low during STREAM at beat 4, then released -> no trace_done, busy=0, next grant passes through INIT with index 0.

Source files
------------

// File: rtl/monitor_sequencer.sv
// monitor_sequencer
//   Arbitrates symbol traces from NUM_REQ requesters into a single automaton.
//   Each trace is framed by INIT (automaton reset) and DRAIN (final report
//   sample). Nonzero automaton reports are flagged as violations tagged with
//   the owner and the index of the beat that produced them.
//
//   Build option: MONITOR_SEQ_EARLY_ABORT_EN. When defined, the first
//   violation of a trace stops feeding the automaton. The remaining beats of
//   that trace are then discarded until req_last.
//
//   Ports
//     clk, reset_n               clock, synchronous active-low reset
//     req_valid/symbol/last      per-requester beat stream (symbol packed 8b each)
//     req_ready                  per-requester accept
//     auto_reset/run/symbols     automaton drive
//     auto_report                automaton report-state inputs
//     viol_valid/src/report/index   violation pulse and its qualifiers
//     trace_done/src/viol        end-of-trace pulse and summary
//     busy                       high when not IDLE
//
//   state  | meaning
//   IDLE   | waiting for any req_valid, round-robin grant
//   INIT   | one-cycle automaton reset, beat index cleared
//   STREAM | owner beats forwarded to automaton
//   DRAIN  | one cycle to sample the report of the last beat
//   DONE   | trace_done pulse, advance round-robin pointer
//   ABORT  | (early-abort build) discard owner beats until req_last
module monitor_sequencer #(
   parameter int NUM_REQ    = 2,
   parameter int NUM_REPORT = 4,
   parameter int IDX_W      = 16,
   localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*8-1:0]    req_symbol,
   input  logic [NUM_REQ-1:0]      req_last,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    auto_reset,
   output logic                    auto_run,
   output logic [7:0]              auto_symbols,
   input  logic [NUM_REPORT-1:0]   auto_report,
   output logic                    viol_valid,
   output logic [SRC_W-1:0]        viol_src,
   output logic [NUM_REPORT-1:0]   viol_report,
   output logic [IDX_W-1:0]        viol_index,
   output logic                    trace_done,
   output logic [SRC_W-1:0]        trace_src,
   output logic                    trace_viol,
   output logic                    busy
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      INIT   = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4,
      ABORT  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [SRC_W-1:0]  owner_q, owner_d;
   logic [SRC_W-1:0]  rr_q, rr_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              pend_q, pend_d;        // a beat was accepted last cycle
   logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;
   logic              tviol_q, tviol_d;

   logic              own_valid, own_last, viol_now;
   logic [SRC_W-1:0]  grant;
   logic              grant_found;
   int                cand;

   assign own_valid = req_valid[owner_q];
   assign own_last  = req_last[owner_q];
   assign viol_now  = pend_q && (auto_report != '0);

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         rr_q       <= '0;
         idx_q      <= '0;
         pend_q     <= 1'b0;
         pend_idx_q <= '0;
         tviol_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_q       <= rr_d;
         idx_q      <= idx_d;
         pend_q     <= pend_d;
         pend_idx_q <= pend_idx_d;
         tviol_q    <= tviol_d;
      end
   end

   // Round-robin search starting at rr_q
   always_comb begin
      grant       = rr_q;
      grant_found = 1'b0;
      cand        = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(rr_q) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant       = SRC_W'(cand);
         end
      end
   end

   // Next-state
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_d       = rr_q;
      idx_d      = idx_q;
      pend_d     = 1'b0;
      pend_idx_d = pend_idx_q;
      tviol_d    = tviol_q | viol_now;
      case (state_q)
         IDLE: begin
            if (grant_found) begin
               owner_d = grant;
               state_d = INIT;
            end
         end
         INIT: begin
            idx_d   = '0;
            tviol_d = 1'b0;
            state_d = STREAM;
         end
         STREAM: begin
`ifdef MONITOR_SEQ_EARLY_ABORT_EN
            // The beat presented alongside the first violation is discarded.
            if (viol_now) begin
               state_d = (own_valid && own_last) ? DONE : ABORT;
            end else
`endif
            if (own_valid) begin
               pend_d     = 1'b1;
               pend_idx_d = idx_q;
               idx_d      = (&idx_q) ? idx_q : idx_q + 1'b1;
               if (own_last) state_d = DRAIN;
            end
         end
`ifdef MONITOR_SEQ_EARLY_ABORT_EN
         ABORT: begin
            if (own_valid && own_last) state_d = DONE;
         end
`endif
         DRAIN: state_d = DONE;
         DONE: begin
            rr_d    = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      req_ready    = '0;
      auto_run     = 1'b0;
      auto_symbols = 8'h00;
      if (state_q == STREAM) begin
         req_ready[owner_q] = 1'b1;
         auto_symbols       = req_symbol[8*int'(owner_q) +: 8];
`ifdef MONITOR_SEQ_EARLY_ABORT_EN
         auto_run           = own_valid && !viol_now;
`else
         auto_run           = own_valid;
`endif
      end
`ifdef MONITOR_SEQ_EARLY_ABORT_EN
      if (state_q == ABORT) req_ready[owner_q] = 1'b1;
`endif
      auto_reset  = (state_q == INIT) || !reset_n;
      viol_valid  = viol_now;
      viol_src    = owner_q;
      viol_report = auto_report;
      viol_index  = pend_idx_q;
      trace_done  = (state_q == DONE);
      trace_src   = owner_q;
      trace_viol  = tviol_q;
      busy        = (state_q != IDLE);
   end

endmodule
